// File: rtl/ld_mode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ld_mode_ctrl_if
// Description : Board I/O bundle for the LED mode controller (switches,
//               buttons, LEDs and current mode).
// Revision    : 1.0 - initial release
// ============================================================================
interface ld_mode_ctrl_if;
    logic [7:0] sw;
    logic [1:0] bt;
    logic [7:0] ld;
    logic [1:0] mode;

    modport master (
        output sw,
        output bt,
        input  ld,
        input  mode
    );

    modport slave (
        input  sw,
        input  bt,
        output ld,
        output mode
    );
endinterface
`default_nettype wire

// File: rtl/ld_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ld_mode_ctrl
// Description : Selects what drives the 8 LEDs: switch pass-through, ticking
//               counter, rotating pattern or freeze; bt[0] steps, bt[1] loads.
// Revision    : 1.0 - initial release
// ============================================================================
module ld_mode_ctrl #(
    parameter int TICK_DIV = 12500000,
    parameter int DIV_W    = 24
) (
    input  wire logic         clk,
    input  wire logic         rst,
    ld_mode_ctrl_if.slave     bus
);

    localparam logic [1:0]       c_MODE_PASS  = 2'd0;
    localparam logic [1:0]       c_MODE_COUNT = 2'd1;
    localparam logic [1:0]       c_MODE_SHIFT = 2'd2;
    localparam logic [1:0]       c_MODE_HOLD  = 2'd3;
    localparam logic [DIV_W-1:0] c_TICK_MAX   = DIV_W'(TICK_DIV - 1);

    logic [1:0]       r_s1;
    logic [1:0]       r_s2;
    logic [1:0]       r_s3;
    logic [1:0]       w_press;
    logic             w_step;
    logic             w_load;

    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    logic [1:0]       r_mode;
    logic [1:0]       w_mode_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic [7:0]       r_pat;
    logic [7:0]       w_pat_nxt;
    logic [7:0]       r_ld;
    logic [7:0]       w_ld_nxt;

    assign w_press = r_s2 & ~r_s3;
    assign w_step  = w_press[0];
    assign w_load  = w_press[1];
    assign w_tick  = (r_div == c_TICK_MAX);

    // Button synchronizers plus edge-detect delay; reset to 0 so a button held
    // through reset release still yields exactly one press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 2'b00;
            r_s2 <= 2'b00;
            r_s3 <= 2'b00;
        end else begin
            r_s1 <= bus.bt;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Prescaler restarts on every mode change so a fresh mode gets a full period.
    always_ff @(posedge clk) begin
        if (rst || w_step || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= c_MODE_PASS;
            r_cnt  <= 8'h00;
            r_pat  <= 8'h01;
            r_ld   <= 8'h00;
        end else begin
            r_mode <= w_mode_nxt;
            r_cnt  <= w_cnt_nxt;
            r_pat  <= w_pat_nxt;
            r_ld   <= w_ld_nxt;
        end
    end

    // Load and tick act on the current mode; a simultaneous step only moves
    // the mode register, so the load lands in the mode being left.
    always_comb begin
        w_mode_nxt = r_mode;
        w_cnt_nxt  = r_cnt;
        w_pat_nxt  = r_pat;
        w_ld_nxt   = r_ld;

        if (w_step) begin
            w_mode_nxt = r_mode + 2'd1;
        end

        case (r_mode)
            c_MODE_PASS: begin
                w_ld_nxt = bus.sw;
            end
            c_MODE_COUNT: begin
                w_ld_nxt = r_cnt;
                if (w_load) begin
                    w_cnt_nxt = bus.sw;
                end else if (w_tick) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            c_MODE_SHIFT: begin
                w_ld_nxt = r_pat;
                if (w_load) begin
                    // An all-zero pattern would rotate forever as dark LEDs.
                    w_pat_nxt = (bus.sw == 8'h00) ? 8'h01 : bus.sw;
                end else if (w_tick) begin
                    w_pat_nxt = {r_pat[6:0], r_pat[7]};
                end
            end
            c_MODE_HOLD: begin
                w_ld_nxt = r_ld;
            end
            default: begin
                w_ld_nxt = r_ld;
            end
        endcase
    end

    assign bus.ld   = r_ld;
    assign bus.mode = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_ld_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ld_mode_ctrl
// Description : Directed plus randomized bench for ld_mode_ctrl against a
//               cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ld_mode_ctrl;

    localparam int TICK_DIV = 4;
    localparam int DIV_W    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ld_mode_ctrl_if bus ();

    ld_mode_ctrl #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state, expressed as the spec's observable rules.
    int         m_mode = 0;
    logic [7:0] m_cnt  = 8'h00;
    logic [7:0] m_pat  = 8'h01;
    logic [7:0] m_ld   = 8'h00;
    int         m_age  = 0;        // edges since last reset or mode change
    logic [1:0] bt_hist[$] = '{2'b00, 2'b00, 2'b00}; // [0] = sample at previous edge

    always @(posedge clk) begin
        logic [1:0] press;
        logic       tick;
        logic [7:0] ld_new;
        if (rst) begin
            m_mode = 0;
            m_cnt  = 8'h00;
            m_pat  = 8'h01;
            m_ld   = 8'h00;
            m_age  = 0;
            bt_hist = '{2'b00, 2'b00, 2'b00};
        end else begin
            // A press takes effect two edges after the first edge that sees the button high.
            press = bt_hist[1] & ~bt_hist[2];
            tick  = ((m_age % TICK_DIV) == TICK_DIV - 1);
            ld_new = m_ld;
            case (m_mode)
                0: ld_new = bus.sw;
                1: begin
                    ld_new = m_cnt;
                    if (press[1])  m_cnt = bus.sw;
                    else if (tick) m_cnt = m_cnt + 8'd1;
                end
                2: begin
                    ld_new = m_pat;
                    if (press[1])  m_pat = (bus.sw == 8'h00) ? 8'h01 : bus.sw;
                    else if (tick) m_pat = {m_pat[6:0], m_pat[7]};
                end
                default: ld_new = m_ld;
            endcase
            m_ld = ld_new;
            if (press[0]) begin
                m_mode = (m_mode + 1) % 4;
                m_age  = 0;
            end else begin
                m_age = m_age + 1;
            end
            bt_hist.push_front(bus.bt);
            void'(bt_hist.pop_back());
        end
    end

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Compare outputs after the previous edge, then drive inputs for the next one.
    task automatic cycle(input logic [7:0] s, input logic [1:0] b, input logic r);
        @(negedge clk);
        check_eq("ld", bus.ld, m_ld);
        check_eq("mode", {6'b0, bus.mode}, 8'(m_mode));
        bus.sw = s;
        bus.bt = b;
        rst    = r;
    endtask

    task automatic hold(input int n, input logic [7:0] s, input logic [1:0] b);
        for (int i = 0; i < n; i++) cycle(s, b, 1'b0);
    endtask

    task automatic press(input logic [7:0] s, input logic [1:0] b);
        hold(2, s, b);
        hold(4, s, 2'b00);
    endtask

    initial begin
        logic [7:0] s;
        logic [1:0] b;
        bus.sw = 8'hA5;
        bus.bt = 2'b00;
        // Reset, then pass-through
        cycle(8'hA5, 2'b00, 1'b1);
        cycle(8'hA5, 2'b00, 1'b1);
        cycle(8'hA5, 2'b00, 1'b0);
        hold(2, 8'h3C, 2'b00);
        // COUNT with wrap from FE
        press(8'h3C, 2'b01);
        press(8'hFE, 2'b10);
        hold(20, 8'h00, 2'b00);
        // SHIFT with zero-load guard, then 0x81
        press(8'h00, 2'b01);
        press(8'h00, 2'b10);
        hold(10, 8'h00, 2'b00);
        press(8'h81, 2'b10);
        hold(6, 8'h00, 2'b00);
        // HOLD: sw toggles, load ignored, then wrap to PASS
        press(8'h55, 2'b01);
        for (int i = 0; i < 20; i++) cycle(8'(i * 37), 2'b00, 1'b0);
        press(8'hAA, 2'b10);
        press(8'h5A, 2'b01);
        hold(3, 8'hC3, 2'b00);
        // COUNT: simultaneous step and load
        press(8'h00, 2'b01);
        press(8'h10, 2'b11);
        hold(6, 8'h00, 2'b00);
        // Reset mid-SHIFT with load button held through release
        hold(4, 8'h40, 2'b10);
        cycle(8'h40, 2'b10, 1'b1);
        cycle(8'h40, 2'b10, 1'b1);
        hold(10, 8'h40, 2'b10);
        hold(3, 8'h40, 2'b00);
        // Randomized operation
        s = 8'h00;
        b = 2'b00;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) s = 8'($urandom);
            if ($urandom_range(0, 5) == 0) b[0] = ~b[0];
            if ($urandom_range(0, 5) == 0) b[1] = ~b[1];
            cycle(s, b, ($urandom_range(0, 299) == 0));
        end
        cycle(8'h00, 2'b00, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
